// File: rtl/stage_event_logger_if.sv
// Readout bus of the stage event logger: first-word-fall-through valid/ready
// record stream plus the current FIFO occupancy.
// master = logger side, slave = host/consumer side.
interface stage_event_logger_if #(
    parameter int DEPTH = 16
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             evt_rdy_i;
    logic             evt_vld_o;
    logic [31:0]      evt_data_o;
    logic [CNT_W-1:0] evt_cnt_o;

    modport master (
        input  evt_rdy_i,
        output evt_vld_o,
        output evt_data_o,
        output evt_cnt_o
    );

    modport slave (
        output evt_rdy_i,
        input  evt_vld_o,
        input  evt_data_o,
        input  evt_cnt_o
    );
endinterface

// File: rtl/stage_event_logger.sv
// Timestamped logger for the pipeline stage handshake flags.
// Each level change on status_i is stamped with a free-running cycle count,
// held in a per-flag pending slot, and moved into a record FIFO one record
// per cycle (lowest flag index first). The host drains the FIFO through a
// first-word-fall-through valid/ready port.
// Build option: define STAGE_EVT_FALL_EN to log falling edges as well as
// rising edges; without it only rises are logged and bit 28 is always 1.
// Record: [31:29] flag index, [28] new level, [27:TS_W] zero, [TS_W-1:0] stamp.
module stage_event_logger #(
    parameter int NUM_FLAGS = 8,
    parameter int DEPTH     = 16,
    parameter int TS_W      = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLAGS-1:0]  status_i,
    input  logic                  clear_i,
    stage_event_logger_if.master  evt,
    output logic                  overflow_o
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam int PAD_W = 28 - TS_W;

    logic [TS_W-1:0]      ts_reg;
    logic [NUM_FLAGS-1:0] prev_reg;
    logic [NUM_FLAGS-1:0] chg_evt;

    logic [NUM_FLAGS-1:0] pend_vec;
    logic [NUM_FLAGS-1:0] pend_lvl_vec;
    logic [TS_W-1:0]      pend_ts_arr [NUM_FLAGS];

    logic [NUM_FLAGS-1:0] emit_onehot;
    logic                 emit_vld;
    logic [2:0]           emit_idx;
    logic                 emit_lvl;
    logic [TS_W-1:0]      emit_ts;
    logic [31:0]          emit_rec;

    logic [31:0]          mem [DEPTH];
    logic [AW-1:0]        wr_ptr_reg;
    logic [AW-1:0]        rd_ptr_reg;
    logic [CNT_W-1:0]     count_reg;
    logic                 ovf_reg;

    logic                 fifo_full;
    logic                 fifo_nempty;
    logic                 pop;
    logic                 push;
    logic                 drop;
    logic                 pend_lost;

    // Flags that produce an event this cycle
`ifdef STAGE_EVT_FALL_EN
    assign chg_evt = status_i ^ prev_reg;
`else
    assign chg_evt = status_i & ~prev_reg;
`endif

    // Free-running timestamp and previous-level copy; clear realigns both
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_reg   <= '0;
            prev_reg <= '0;
        end else if (clear_i) begin
            ts_reg   <= '0;
            prev_reg <= status_i;
        end else begin
            ts_reg   <= ts_reg + TS_W'(1);
            prev_reg <= status_i;
        end
    end

    // Per-flag pending slot: a new change wins over an older unsent one
    for (genvar gi = 0; gi < NUM_FLAGS; gi++) begin : g_pend
        logic            bit_reg;
        logic [TS_W-1:0] ts_r;

        // Pending bit and stamp; a change on the flag being emitted re-arms it
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                bit_reg <= 1'b0;
                ts_r    <= '0;
            end else if (clear_i) begin
                bit_reg <= 1'b0;
            end else if (chg_evt[gi]) begin
                bit_reg <= 1'b1;
                ts_r    <= ts_reg;
            end else if (emit_onehot[gi]) begin
                bit_reg <= 1'b0;
            end
        end

`ifdef STAGE_EVT_FALL_EN
        logic lvl_reg;

        // Level captured alongside the stamp
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                lvl_reg <= 1'b0;
            end else if (!clear_i && chg_evt[gi]) begin
                lvl_reg <= status_i[gi];
            end
        end

        assign pend_lvl_vec[gi] = lvl_reg;
`else
        assign pend_lvl_vec[gi] = 1'b1;
`endif

        assign pend_vec[gi]    = bit_reg;
        assign pend_ts_arr[gi] = ts_r;
    end

    // Lowest-index pending flag is the one emitted this cycle
    always_comb begin
        emit_idx = '0;
        emit_lvl = 1'b0;
        emit_ts  = '0;
        for (int i = NUM_FLAGS - 1; i >= 0; i--) begin
            if (pend_vec[i]) begin
                emit_idx = 3'(i);
                emit_lvl = pend_lvl_vec[i];
                emit_ts  = pend_ts_arr[i];
            end
        end
    end

    assign emit_vld    = |pend_vec;
    assign emit_onehot = pend_vec & (~pend_vec + NUM_FLAGS'(1));
    assign emit_rec    = {emit_idx, emit_lvl, {PAD_W{1'b0}}, emit_ts};

    assign fifo_nempty = (count_reg != '0);
    assign fifo_full   = (count_reg == CNT_W'(DEPTH));
    assign pop         = fifo_nempty & evt.evt_rdy_i & ~clear_i;
    // A full FIFO still accepts a record when the head leaves in the same cycle
    assign push        = emit_vld & ~clear_i & (~fifo_full | pop);
    assign drop        = emit_vld & fifo_full & ~pop;
    assign pend_lost   = |(chg_evt & pend_vec & ~emit_onehot);

    // Record storage; no reset needed, occupancy gates visibility
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= emit_rec;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CNT_W'(1);
            end
        end
    end

    // Sticky loss flag: overwritten pending record or record dropped at full
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_reg <= 1'b0;
        end else if (clear_i) begin
            ovf_reg <= 1'b0;
        end else if (pend_lost || drop) begin
            ovf_reg <= 1'b1;
        end
    end

    assign evt.evt_vld_o  = fifo_nempty;
    assign evt.evt_data_o = fifo_nempty ? mem[rd_ptr_reg] : 32'd0;
    assign evt.evt_cnt_o  = count_reg;
    assign overflow_o     = ovf_reg;

endmodule

// File: tb/tb_stage_event_logger.sv
// Directed bench for stage_event_logger. A second instance with a 4-bit
// timestamp exercises the wrap from all-ones to zero in a few cycles.
// Expectations follow STAGE_EVT_FALL_EN when it is defined at compile time.
module tb_stage_event_logger;

    logic       clk;
    logic       rst_n;
    logic [7:0] status;
    logic       clear;
    logic       ovf;
    logic [7:0] status_w;
    logic       clear_w;
    logic       ovf_w;

    int tests_run;
    int tests_failed;

    stage_event_logger_if #(.DEPTH(16)) evt_if ();
    stage_event_logger_if #(.DEPTH(16)) evt_w_if ();

    stage_event_logger #(
        .NUM_FLAGS(8),
        .DEPTH(16),
        .TS_W(24)
    ) u_dut (
        .clk(clk),
        .rst_n(rst_n),
        .status_i(status),
        .clear_i(clear),
        .evt(evt_if),
        .overflow_o(ovf)
    );

    stage_event_logger #(
        .NUM_FLAGS(8),
        .DEPTH(16),
        .TS_W(4)
    ) u_dut_w (
        .clk(clk),
        .rst_n(rst_n),
        .status_i(status_w),
        .clear_i(clear_w),
        .evt(evt_w_if),
        .overflow_o(ovf_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Clear the main instance; after return the current cycle has ts_q = 0
    task automatic do_clear(input logic [7:0] s);
        status = s;
        clear  = 1'b1;
        step();
        clear  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        tests_run++;
        if (evt_if.evt_vld_o !== 1'b0 || evt_if.evt_data_o !== 32'd0 ||
            evt_if.evt_cnt_o !== 5'd0 || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_values: vld=%b data=%h cnt=%0d ovf=%b, need 0/0/0/0",
                     evt_if.evt_vld_o, evt_if.evt_data_o, evt_if.evt_cnt_o, ovf);
        end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            tests_run++;
            if (evt_if.evt_vld_o !== 1'b0 || evt_if.evt_cnt_o !== 5'd0 || ovf !== 1'b0) begin
                tests_failed++;
                $display("FAIL idle_quiet cycle %0d: vld=%b cnt=%0d ovf=%b, need 0/0/0",
                         i, evt_if.evt_vld_o, evt_if.evt_cnt_o, ovf);
            end
        end
        $display("[TB] reset/idle done");
    endtask

    task automatic test_single();
        do_clear(8'h00);
        repeat (5) step();
        status = 8'h80;             // flag 7 rises while ts_q = 5
        step();
        tests_run++;
        if (evt_if.evt_vld_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_pending: vld=%b, need 0", evt_if.evt_vld_o);
        end
        step();
        tests_run++;
        if (evt_if.evt_vld_o !== 1'b1 || evt_if.evt_data_o !== 32'hF000_0005 ||
            evt_if.evt_cnt_o !== 5'd1) begin
            tests_failed++;
            $display("FAIL single_record: vld=%b data=%h cnt=%0d, need 1/f0000005/1",
                     evt_if.evt_vld_o, evt_if.evt_data_o, evt_if.evt_cnt_o);
        end
        repeat (3) begin
            step();
            tests_run++;
            if (evt_if.evt_data_o !== 32'hF000_0005) begin
                tests_failed++;
                $display("FAIL single_hold: data=%h, need f0000005", evt_if.evt_data_o);
            end
        end
        $display("[TB] pop %h", evt_if.evt_data_o);
        evt_if.evt_rdy_i = 1'b1;
        step();
        evt_if.evt_rdy_i = 1'b0;
        tests_run++;
        if (evt_if.evt_vld_o !== 1'b0 || evt_if.evt_cnt_o !== 5'd0) begin
            tests_failed++;
            $display("FAIL single_pop: vld=%b cnt=%0d, need 0/0",
                     evt_if.evt_vld_o, evt_if.evt_cnt_o);
        end
    endtask

    task automatic test_multi();
        logic [31:0] exp_q [3];
        exp_q[0] = 32'h1000_0014;
        exp_q[1] = 32'h7000_0014;
        exp_q[2] = 32'hD000_0014;
        do_clear(8'h00);
        repeat (20) step();
        status = 8'h49;             // flags 0, 3, 6 rise while ts_q = 20
        repeat (4) step();
        tests_run++;
        if (evt_if.evt_cnt_o !== 5'd3 || evt_if.evt_data_o !== exp_q[0]) begin
            tests_failed++;
            $display("FAIL multi_fill: cnt=%0d head=%h, need 3/%h",
                     evt_if.evt_cnt_o, evt_if.evt_data_o, exp_q[0]);
        end
        for (int j = 0; j < 3; j++) begin
            tests_run++;
            if (evt_if.evt_vld_o !== 1'b1 || evt_if.evt_data_o !== exp_q[j]) begin
                tests_failed++;
                $display("FAIL multi_order rec %0d: vld=%b data=%h, need 1/%h",
                         j, evt_if.evt_vld_o, evt_if.evt_data_o, exp_q[j]);
            end
            $display("[TB] pop %h", evt_if.evt_data_o);
            evt_if.evt_rdy_i = 1'b1;
            step();
            evt_if.evt_rdy_i = 1'b0;
        end
        tests_run++;
        if (evt_if.evt_vld_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL multi_empty: vld=%b, need 0", evt_if.evt_vld_o);
        end
    endtask

    task automatic test_overflow();
        int          stride;
        int          n_cyc;
        logic [31:0] exp_rec;
        logic [23:0] ts_v;
        logic [23:0] last_ts;
        logic        lvl;
`ifdef STAGE_EVT_FALL_EN
        stride = 1;
`else
        stride = 2;
`endif
        n_cyc = 16 * stride + 1;    // 17 logged edges
        do_clear(8'h00);
        for (int c = 0; c < n_cyc; c++) begin
            status = {7'd0, ~c[0]};
            step();
        end
        repeat (2) step();
        tests_run++;
        if (evt_if.evt_cnt_o !== 5'd16 || ovf !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_full: cnt=%0d ovf=%b, need 16/1", evt_if.evt_cnt_o, ovf);
        end
        last_ts = '0;
        for (int j = 0; j < 16; j++) begin
            ts_v = 24'(j * stride);
`ifdef STAGE_EVT_FALL_EN
            lvl = ~j[0];
`else
            lvl = 1'b1;
`endif
            exp_rec = {3'd0, lvl, 4'd0, ts_v};
            tests_run++;
            if (evt_if.evt_data_o !== exp_rec) begin
                tests_failed++;
                $display("FAIL ovf_drain rec %0d: data=%h, need %h", j, evt_if.evt_data_o, exp_rec);
            end
            if (j > 0) begin
                tests_run++;
                if (!(evt_if.evt_data_o[23:0] > last_ts)) begin
                    tests_failed++;
                    $display("FAIL ovf_monotonic rec %0d: ts=%h, need > %h",
                             j, evt_if.evt_data_o[23:0], last_ts);
                end
            end
            last_ts = evt_if.evt_data_o[23:0];
            $display("[TB] pop %h", evt_if.evt_data_o);
            evt_if.evt_rdy_i = 1'b1;
            step();
            evt_if.evt_rdy_i = 1'b0;
        end
        tests_run++;
        if (evt_if.evt_vld_o !== 1'b0 || ovf !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_sticky: vld=%b ovf=%b, need 0/1", evt_if.evt_vld_o, ovf);
        end
        do_clear(8'h00);
        tests_run++;
        if (ovf !== 1'b0 || evt_if.evt_cnt_o !== 5'd0) begin
            tests_failed++;
            $display("FAIL ovf_clear: ovf=%b cnt=%0d, need 0/0", ovf, evt_if.evt_cnt_o);
        end
    endtask

    task automatic test_fall();
        do_clear(8'h04);
        repeat (256) step();
        status = 8'h00;             // flag 2 falls while ts_q = 0x100
        repeat (2) step();
`ifdef STAGE_EVT_FALL_EN
        tests_run++;
        if (evt_if.evt_vld_o !== 1'b1 || evt_if.evt_data_o !== 32'h4000_0100 ||
            evt_if.evt_cnt_o !== 5'd1) begin
            tests_failed++;
            $display("FAIL fall_record: vld=%b data=%h cnt=%0d, need 1/40000100/1",
                     evt_if.evt_vld_o, evt_if.evt_data_o, evt_if.evt_cnt_o);
        end
        $display("[TB] pop %h", evt_if.evt_data_o);
        evt_if.evt_rdy_i = 1'b1;
        step();
        evt_if.evt_rdy_i = 1'b0;
`else
        tests_run++;
        if (evt_if.evt_vld_o !== 1'b0 || evt_if.evt_cnt_o !== 5'd0) begin
            tests_failed++;
            $display("FAIL fall_ignored: vld=%b cnt=%0d, need 0/0",
                     evt_if.evt_vld_o, evt_if.evt_cnt_o);
        end
`endif
    endtask

    task automatic test_back_to_back();
        int          k;
        int          n_exp;
        logic [31:0] exp_rec;
        logic        lvl;
        logic [23:0] ts_v;
`ifdef STAGE_EVT_FALL_EN
        n_exp = 20;
`else
        n_exp = 10;
`endif
        do_clear(8'h00);
        evt_if.evt_rdy_i = 1'b1;
        k = 0;
        for (int c = 0; c < 24; c++) begin
            if (c < 20) status = {6'd0, ~c[0], 1'b0};
            tests_run++;
            if (evt_if.evt_cnt_o > 5'd1) begin
                tests_failed++;
                $display("FAIL b2b_occupancy cycle %0d: cnt=%0d, need <= 1", c, evt_if.evt_cnt_o);
            end
            if (evt_if.evt_vld_o === 1'b1) begin
`ifdef STAGE_EVT_FALL_EN
                ts_v = 24'(k);
                lvl  = ~k[0];
`else
                ts_v = 24'(2 * k);
                lvl  = 1'b1;
`endif
                exp_rec = {3'd1, lvl, 4'd0, ts_v};
                tests_run++;
                if (evt_if.evt_data_o !== exp_rec) begin
                    tests_failed++;
                    $display("FAIL b2b_record %0d: data=%h, need %h", k, evt_if.evt_data_o, exp_rec);
                end
                $display("[TB] pop %h", evt_if.evt_data_o);
                k++;
            end
            step();
        end
        evt_if.evt_rdy_i = 1'b0;
        tests_run++;
        if (k !== n_exp || ovf !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_count: popped=%0d ovf=%b, need %0d/0", k, ovf, n_exp);
        end
    endtask

    task automatic test_reset_midrun();
        do_clear(8'h00);
        status = 8'h01;
        repeat (2) step();
        tests_run++;
        if (evt_if.evt_cnt_o !== 5'd1) begin
            tests_failed++;
            $display("FAIL midrun_queued: cnt=%0d, need 1", evt_if.evt_cnt_o);
        end
        rst_n  = 1'b0;
        status = 8'h40;
        #1;
        tests_run++;
        if (evt_if.evt_vld_o !== 1'b0 || evt_if.evt_cnt_o !== 5'd0) begin
            tests_failed++;
            $display("FAIL midrun_flush: vld=%b cnt=%0d, need 0/0",
                     evt_if.evt_vld_o, evt_if.evt_cnt_o);
        end
        step();
        rst_n = 1'b1;               // this cycle has ts_q = 0
        repeat (2) step();
        tests_run++;
        if (evt_if.evt_cnt_o !== 5'd1 || evt_if.evt_data_o !== 32'hD000_0000) begin
            tests_failed++;
            $display("FAIL midrun_high_flag: cnt=%0d data=%h, need 1/d0000000",
                     evt_if.evt_cnt_o, evt_if.evt_data_o);
        end
        $display("[TB] pop %h", evt_if.evt_data_o);
        evt_if.evt_rdy_i = 1'b1;
        step();
        evt_if.evt_rdy_i = 1'b0;
    endtask

    task automatic test_wrap();
        status_w = 8'h00;
        clear_w  = 1'b1;
        step();
        clear_w  = 1'b0;            // ts_q = 0 in this cycle
        repeat (15) step();
        status_w = 8'h20;           // flag 5 rises at ts_q = 0xF
        step();
        status_w = 8'h30;           // flag 4 rises at ts_q = 0x0
        repeat (2) step();
        tests_run++;
        if (evt_w_if.evt_cnt_o !== 5'd2 || evt_w_if.evt_data_o !== 32'hB000_000F) begin
            tests_failed++;
            $display("FAIL wrap_first: cnt=%0d data=%h, need 2/b000000f",
                     evt_w_if.evt_cnt_o, evt_w_if.evt_data_o);
        end
        $display("[TB] pop %h", evt_w_if.evt_data_o);
        evt_w_if.evt_rdy_i = 1'b1;
        step();
        tests_run++;
        if (evt_w_if.evt_data_o !== 32'h9000_0000) begin
            tests_failed++;
            $display("FAIL wrap_second: data=%h, need 90000000", evt_w_if.evt_data_o);
        end
        $display("[TB] pop %h", evt_w_if.evt_data_o);
        step();
        evt_w_if.evt_rdy_i = 1'b0;
        tests_run++;
        if (evt_w_if.evt_vld_o !== 1'b0 || ovf_w !== 1'b0) begin
            tests_failed++;
            $display("FAIL wrap_empty: vld=%b ovf=%b, need 0/0", evt_w_if.evt_vld_o, ovf_w);
        end
    endtask

    initial begin
        tests_run          = 0;
        tests_failed       = 0;
        rst_n              = 1'b0;
        status             = 8'h00;
        clear              = 1'b0;
        status_w           = 8'h00;
        clear_w            = 1'b0;
        evt_if.evt_rdy_i   = 1'b0;
        evt_w_if.evt_rdy_i = 1'b0;

        test_reset();
        test_single();
        test_multi();
        test_overflow();
        test_fall();
        test_back_to_back();
        test_reset_midrun();
        test_wrap();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
